// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write-side companion of the instruction memory. The loader receives a byte
// stream over a valid/ready handshake and packs the bytes into little-endian
// 32-bit words. Each finished word is written to the next imem word address.
// The CPU stays in reset (cpu_rst low) until the whole image has been written.
//
// Stream format: len[7:0], len[15:8] (N = number of words), then 4*N data
// bytes. Inside a word, byte0 lands in [7:0] and byte3 lands in [31:24].
//
// Parameters
//   ADDR_W      imem word-address width
//   DEPTH       largest accepted word count (must be <= 2**ADDR_W)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle pulse that begins a load (honoured in IDLE/DONE)
//   in_data     stream byte
//   in_valid    in_data is valid
//   in_ready    loader accepts a byte this cycle
//   imem_we     imem write strobe, one-cycle pulse per word
//   imem_addr   imem word address (holds the last written value)
//   imem_wdata  imem write data (holds the last written value)
//   busy        load in progress (LEN0 through FLUSH)
//   done        image complete, level until the next start or reset
//   err         length larger than DEPTH, sticky until reset
//   cpu_rst     active-low CPU reset, high only in DONE
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_rst
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_FLUSH,
      S_DONE,
      S_ERR
   } state_t;

   // Width-safe copy of DEPTH for comparison against the 16-bit length field.
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t       state;
   logic [1:0]   byte_cnt;   // byte position inside the current word
   logic [15:0]  word_cnt;   // index k of the word being assembled
   logic [15:0]  len;        // N, the word count announced by the header
   logic [31:0]  asm_word;   // bytes 0..2 of the word being assembled

   logic         xfer;
   logic [16:0]  len_next;   // full length as it becomes known in LEN1
   logic         last_word;

   assign xfer      = in_valid & in_ready;
   assign len_next  = {1'b0, in_data, len[7:0]};
   // Only meaningful in DATA, where N >= 1 so N-1 cannot underflow.
   assign last_word = (word_cnt == (len - 16'd1));

   // NOTE: every register is updated with non-blocking assignments so all of
   // them see the values from before the clock edge, whatever the order of
   // the statements below.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         byte_cnt   <= 2'd0;
         word_cnt   <= 16'd0;
         len        <= 16'd0;
         asm_word   <= 32'd0;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         cpu_rst    <= 1'b0;
      end else begin
         // NOTE: the write strobe defaults low every cycle. This gives a
         // one-cycle pulse without extra clear logic in each state.
         imem_we <= 1'b0;

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_LEN0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  cpu_rst  <= 1'b0;
                  byte_cnt <= 2'd0;
                  word_cnt <= 16'd0;
                  len      <= 16'd0;
                  asm_word <= 32'd0;
               end
            end

            S_LEN0: begin
               if (xfer) begin
                  len[7:0] <= in_data;
                  state    <= S_LEN1;
               end
            end

            S_LEN1: begin
               if (xfer) begin
                  len[15:8] <= in_data;
                  if (len_next == 17'd0) begin
                     // An empty image is complete as soon as its header ends.
                     state    <= S_DONE;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     cpu_rst  <= 1'b1;
                  end else if (len_next > DEPTH_L) begin
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (xfer) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  asm_word[{byte_cnt, 3'b000} +: 8] <= in_data;
                  if (byte_cnt == 2'd3) begin
                     // The fourth byte goes straight into the write data, so
                     // the strobe comes one cycle after the transfer and the
                     // stream never stalls.
                     imem_we    <= 1'b1;
                     imem_addr  <= word_cnt[ADDR_W-1:0];
                     imem_wdata <= {in_data, asm_word[23:0]};
                     if (last_word) begin
                        state    <= S_FLUSH;
                        in_ready <= 1'b0;
                     end else begin
                        word_cnt <= word_cnt + 16'd1;
                     end
                  end
               end
            end

            S_FLUSH: begin
               // The last write pulse is visible during this cycle.
               state   <= S_DONE;
               busy    <= 1'b0;
               done    <= 1'b1;
               cpu_rst <= 1'b1;
            end

            S_ERR: begin
               // Only reset leaves this state. start is ignored here.
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. The stimulus tasks push each expected
// imem write into a scoreboard queue. A separate monitor compares every
// imem_we pulse against the head of that queue. Status outputs are checked
// directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic        cpu_rst;

   imem_loader #(
      .ADDR_W (8),
      .DEPTH  (256)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .cpu_rst    (cpu_rst)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] img[0:3];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Status vector: {busy, done, cpu_rst, err, in_ready}
   task automatic check_status(input string name, input logic [4:0] exp);
      check(name, {27'd0, busy, done, cpu_rst, err, in_ready}, {27'd0, exp});
   endtask

   // Scoreboard monitor. Any write with nothing queued counts as a failure.
   always @(negedge clk) begin
      if (rst === 1'b1 && imem_we === 1'b1) begin
         check("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", {24'd0, imem_addr}, {24'd0, e.addr});
            check("write_data", imem_wdata, e.data);
         end
      end
   end

   // All tasks start and end on a falling edge.
   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_len(input logic [15:0] n, input bit gap);
      send(n[7:0]);
      if (gap) @(negedge clk);
      send(n[15:8]);
      if (gap) @(negedge clk);
   endtask

   // Sends img[0..n-1]. Each word is queued as expected before its bytes go out.
   task automatic send_words(input int n, input bit gap);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{addr: 8'(k), data: img[k]});
         for (int b = 0; b < 4; b++) begin
            send(img[k][8*b +: 8]);
            if (gap && !(k == n - 1 && b == 3)) @(negedge clk);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      in_data  = 8'd0;
      in_valid = 1'b0;
      img[0]   = 32'h0000_0013;
      img[1]   = 32'h0010_0093;
      img[2]   = 32'd0;
      img[3]   = 32'd0;

      // Outputs are cleared while reset is held.
      repeat (2) @(negedge clk);
      check_status("reset_status", 5'b00000);
      check("reset_we", {31'd0, imem_we}, 32'd0);
      check("reset_addr", {24'd0, imem_addr}, 32'd0);
      check("reset_wdata", imem_wdata, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_status("idle_status", 5'b00000);

      // Test 1: two words at one byte per clock.
      pulse_start();
      check_status("len0_status", 5'b10001);
      send_len(16'd2, 1'b0);
      send_words(2, 1'b0);
      check_status("flush_status", 5'b10000);
      @(negedge clk);
      check_status("t1_done", 5'b01100);

      // Test 2: same image, in_valid toggling every cycle.
      pulse_start();
      check_status("t2_len0", 5'b10001);
      send_len(16'd2, 1'b1);
      send_words(2, 1'b1);
      @(negedge clk);
      check_status("t2_done", 5'b01100);

      // Test 3: zero-length image completes right after the header.
      pulse_start();
      send_len(16'd0, 1'b0);
      check_status("t3_done", 5'b01100);
      repeat (2) @(negedge clk);
      check_status("t3_done_hold", 5'b01100);

      // Test 4: N = 257 > DEPTH gives a sticky error. start is ignored.
      pulse_start();
      send_len(16'h0101, 1'b0);
      check_status("t4_err", 5'b00010);
      pulse_start();
      repeat (2) @(negedge clk);
      check_status("t4_err_sticky", 5'b00010);

      // Test 5: reset in the middle of word 0 clears outputs at once.
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      img[0] = 32'hDEAD_BEEF;
      pulse_start();
      send_len(16'd1, 1'b0);
      send(8'hEF);
      send(8'hBE);
      check_status("t5_mid_word", 5'b10001);
      #1 rst = 1'b0;
      #1 check_status("t5_async_reset", 5'b00000);
      check("t5_async_we", {31'd0, imem_we}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pulse_start();
      send_len(16'd1, 1'b0);
      send_words(1, 1'b0);
      @(negedge clk);
      check_status("t5_done", 5'b01100);

      // Test 6: restart from DONE. start in LEN1 is ignored. addr0 is overwritten.
      img[0] = 32'hCAFE_F00D;
      pulse_start();
      check_status("t6_restart", 5'b10001);
      send(8'd1);
      pulse_start();
      check_status("t6_start_ignored", 5'b10001);
      send(8'd0);
      send_words(1, 1'b0);
      check_status("t6_flush", 5'b10000);
      @(negedge clk);
      check_status("t6_done", 5'b01100);

      repeat (2) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
